// File: rtl/canvas_pkg.sv
// -----------------------------------------------------------------------------
// canvas_pkg
// Shared definitions for the canvas painter: grid geometry, the painter FSM
// state encoding, the canvas cell address type and a multiplier-free
// row/col -> linear address helper.
// -----------------------------------------------------------------------------
package canvas_pkg;

    localparam int GRID         = 28;
    localparam int CANVAS_CELLS = GRID * GRID;   // 784

    typedef logic [9:0] canvas_addr_t;           // 0..783
    typedef logic [4:0] cell_idx_t;              // row or column, 0..27

    localparam canvas_addr_t LAST_ADDR = canvas_addr_t'(CANVAS_CELLS - 1);
    localparam cell_idx_t    GRID_MAX  = cell_idx_t'(GRID - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_STAMP = 2'd2
    } state_t;

    // row*28 + col, built as row*32 - row*4 + col so no multiplier is inferred.
    // 27*32 = 864 still fits in 10 bits, so the intermediate never overflows.
    function automatic canvas_addr_t cell_addr(input cell_idx_t row,
                                               input cell_idx_t col);
        canvas_addr_t r_ext;
        canvas_addr_t c_ext;
        r_ext = {5'd0, row};
        c_ext = {5'd0, col};
        return (r_ext << 5) - (r_ext << 2) + c_ext;
    endfunction

endpackage

// File: rtl/canvas_mapper.sv
// -----------------------------------------------------------------------------
// canvas_mapper
// Purely combinational: converts a screen pointer position into a canvas cell.
//
// Ports
//   i_x_pos, i_y_pos : pointer screen position (10 bits each)
//   o_valid          : pointer lies inside the canvas rectangle
//   o_row, o_col     : cell coordinates (meaningful only when o_valid)
//   o_addr           : row*28+col (meaningful only when o_valid)
// -----------------------------------------------------------------------------
module canvas_mapper
    import canvas_pkg::*;
#(
    parameter int CANVAS_X0  = 200,
    parameter int CANVAS_Y0  = 120,
    parameter int CELL_SHIFT = 3
) (
    input  logic [9:0]   i_x_pos,
    input  logic [9:0]   i_y_pos,
    output logic         o_valid,
    output cell_idx_t    o_row,
    output cell_idx_t    o_col,
    output canvas_addr_t o_addr
);

    localparam int SPAN = GRID << CELL_SHIFT;    // canvas side in pixels

    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_in_x;
    logic        w_in_y;

    // One extra bit so the lower-bound test and offset never wrap.
    assign w_x_ext = {1'b0, i_x_pos};
    assign w_y_ext = {1'b0, i_y_pos};
    assign w_dx    = w_x_ext - 11'(CANVAS_X0);
    assign w_dy    = w_y_ext - 11'(CANVAS_Y0);

    assign w_in_x  = (w_x_ext >= 11'(CANVAS_X0)) && (w_dx < 11'(SPAN));
    assign w_in_y  = (w_y_ext >= 11'(CANVAS_Y0)) && (w_dy < 11'(SPAN));

    assign o_valid = w_in_x && w_in_y;
    assign o_col   = cell_idx_t'(w_dx >> CELL_SHIFT);
    assign o_row   = cell_idx_t'(w_dy >> CELL_SHIFT);
    assign o_addr  = cell_addr(o_row, o_col);

endmodule

// File: rtl/canvas_painter.sv
// -----------------------------------------------------------------------------
// canvas_painter
// Turns pointer position and draw/clear buttons into writes to a 28x28 1-bit
// canvas RAM. A clear sweeps every cell to 0; drawing stamps a plus-shaped
// brush (centre + 4 neighbours) once per newly entered cell. Releasing the
// draw button at the end of a stroke requests a classification.
//
// Ports
//   frame_clk  : clock, rising edge
//   Reset      : synchronous, active-high
//   X_pos,Y_pos: pointer screen position
//   draw_btn   : draw button level (synchronous)
//   clear_btn  : clear button level (synchronous)
//   wr_en      : canvas RAM write strobe
//   wr_addr    : canvas cell address row*28+col
//   wr_data    : pixel value written
//   busy       : high while clearing or stamping
//   infer_req  : one-cycle pulse at the end of a stroke
//   clear_done : one-cycle pulse coincident with the last clear write
// -----------------------------------------------------------------------------
module canvas_painter
    import canvas_pkg::*;
#(
    parameter int CANVAS_X0  = 200,
    parameter int CANVAS_Y0  = 120,
    parameter int CELL_SHIFT = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] X_pos,
    input  logic [9:0] Y_pos,
    input  logic       draw_btn,
    input  logic       clear_btn,
    output logic       wr_en,
    output logic [9:0] wr_addr,
    output logic       wr_data,
    output logic       busy,
    output logic       infer_req,
    output logic       clear_done
);

    localparam logic [2:0] STAMP_LAST = 3'd4;    // centre, up, down, left, right

    state_t       r_state;
    canvas_addr_t r_clr_idx;
    logic [2:0]   r_step;
    cell_idx_t    r_row;
    cell_idx_t    r_col;
    canvas_addr_t r_last_addr;
    logic         r_last_valid;
    logic         r_stroke;
    logic         r_draw_d;
    logic         r_clear_d;
    logic         r_infer;

    logic         w_map_valid;
    cell_idx_t    w_map_row;
    cell_idx_t    w_map_col;
    canvas_addr_t w_map_addr;

    logic         w_clear_rise;
    logic         w_clear_pend;
    logic         w_draw_fall;
    logic         w_new_cell;
    logic         w_stamp_go;

    cell_idx_t    w_nb_row;
    cell_idx_t    w_nb_col;
    logic         w_nb_ok;

    canvas_mapper #(
        .CANVAS_X0 (CANVAS_X0),
        .CANVAS_Y0 (CANVAS_Y0),
        .CELL_SHIFT(CELL_SHIFT)
    ) u_mapper (
        .i_x_pos(X_pos),
        .i_y_pos(Y_pos),
        .o_valid(w_map_valid),
        .o_row  (w_map_row),
        .o_col  (w_map_col),
        .o_addr (w_map_addr)
    );

    // Button edge detection against last cycle's level.
    assign w_clear_rise = clear_btn & ~r_clear_d;
    assign w_draw_fall  = r_draw_d & ~draw_btn;

    // Pending clear is acted on at the same edge it is seen, so a clear edge
    // during a stamp cycle ends the stamp right after that cycle. Edges during
    // an ongoing sweep are dropped rather than restarting it.
    assign w_clear_pend = w_clear_rise && (r_state != ST_CLEAR);

    // A stroke stamps its first cell unconditionally, then only on cell change.
    assign w_new_cell   = !r_stroke || !r_last_valid || (w_map_addr != r_last_addr);
    assign w_stamp_go   = draw_btn && w_map_valid && w_new_cell;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_clr_idx    <= '0;
            r_step       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_last_addr  <= '0;
            r_last_valid <= 1'b0;
            r_stroke     <= 1'b0;
            r_draw_d     <= 1'b0;
            r_clear_d    <= 1'b0;
            r_infer      <= 1'b0;
        end else begin
            r_draw_d  <= draw_btn;
            r_clear_d <= clear_btn;
            r_infer   <= 1'b0;

            if (w_clear_pend) begin
                // Clearing forgets the stroke silently: no classification.
                r_state      <= ST_CLEAR;
                r_clr_idx    <= '0;
                r_step       <= '0;
                r_stroke     <= 1'b0;
                r_last_valid <= 1'b0;
            end else begin
                // Stroke end is honoured in any state, including mid-stamp.
                if (w_draw_fall && r_stroke) begin
                    r_infer  <= 1'b1;
                    r_stroke <= 1'b0;
                end

                case (r_state)
                    ST_IDLE: begin
                        if (w_stamp_go) begin
                            r_state      <= ST_STAMP;
                            r_step       <= '0;
                            r_row        <= w_map_row;
                            r_col        <= w_map_col;
                            r_last_addr  <= w_map_addr;
                            r_last_valid <= 1'b1;
                            r_stroke     <= 1'b1;
                        end
                    end
                    ST_CLEAR: begin
                        if (r_clr_idx == LAST_ADDR) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_clr_idx <= r_clr_idx + 10'd1;
                        end
                    end
                    ST_STAMP: begin
                        // Pointer is not looked at here; IDLE re-evaluates it.
                        if (r_step == STAMP_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Brush neighbour for the current stamp step; edge cells suppress the
    // write instead of wrapping to the far side of the canvas.
    always_comb begin
        w_nb_row = r_row;
        w_nb_col = r_col;
        w_nb_ok  = 1'b1;
        case (r_step)
            3'd1: begin
                w_nb_row = r_row - 5'd1;
                w_nb_ok  = (r_row != '0);
            end
            3'd2: begin
                w_nb_row = r_row + 5'd1;
                w_nb_ok  = (r_row != GRID_MAX);
            end
            3'd3: begin
                w_nb_col = r_col - 5'd1;
                w_nb_ok  = (r_col != '0);
            end
            3'd4: begin
                w_nb_col = r_col + 5'd1;
                w_nb_ok  = (r_col != GRID_MAX);
            end
            default: ;
        endcase
    end

    // Outputs decode straight from registered state, so Reset forces them
    // to their idle values on the very next cycle.
    always_comb begin
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = 1'b0;
        clear_done = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                wr_en      = 1'b1;
                wr_addr    = r_clr_idx;
                clear_done = (r_clr_idx == LAST_ADDR);
            end
            ST_STAMP: begin
                wr_en   = w_nb_ok;
                wr_addr = cell_addr(w_nb_row, w_nb_col);
                wr_data = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign infer_req = r_infer;

endmodule

// File: tb/tb_canvas_painter.sv
module tb_canvas_painter;

    logic       frame_clk;
    logic       Reset;
    logic [9:0] X_pos;
    logic [9:0] Y_pos;
    logic       draw_btn;
    logic       clear_btn;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic       wr_data;
    logic       busy;
    logic       infer_req;
    logic       clear_done;

    int n_assert = 0;
    int n_fail   = 0;

    canvas_painter dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .X_pos     (X_pos),
        .Y_pos     (Y_pos),
        .draw_btn  (draw_btn),
        .clear_btn (clear_btn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .infer_req (infer_req),
        .clear_done(clear_done)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        chk({tag, "_wr_addr"},    {22'd0, wr_addr},    32'd0);
        chk({tag, "_wr_data"},    {31'd0, wr_data},    32'd0);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_infer_req"},  {31'd0, infer_req},  32'd0);
        chk({tag, "_clear_done"}, {31'd0, clear_done}, 32'd0);
    endtask

    // Runs a five-cycle stamp starting from the current (first stamp) cycle.
    task automatic chk_stamp(input string tag, input logic [4:0] en_exp,
                             input logic [9:0] a0, input logic [9:0] a1,
                             input logic [9:0] a2, input logic [9:0] a3,
                             input logic [9:0] a4);
        logic [9:0] addrs [5];
        addrs = '{a0, a1, a2, a3, a4};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_en%0d", tag, k), {31'd0, wr_en}, {31'd0, en_exp[k]});
            if (en_exp[k]) begin
                chk($sformatf("%s_addr%0d", tag, k), {22'd0, wr_addr}, {22'd0, addrs[k]});
                chk($sformatf("%s_data%0d", tag, k), {31'd0, wr_data}, 32'd1);
            end
            step();
        end
    endtask

    initial begin
        logic saw;

        Reset     = 1'b1;
        X_pos     = '0;
        Y_pos     = '0;
        draw_btn  = 1'b0;
        clear_btn = 1'b0;
        repeat (3) step();
        chk_idle_outputs("reset");
        Reset = 1'b0;
        step();
        chk_idle_outputs("post_reset");

        // Full clear sweep; a second clear edge mid-sweep must not restart it.
        clear_btn = 1'b1;
        step();
        for (int i = 0; i < 784; i++) begin
            chk($sformatf("clr_busy%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("clr_en%0d", i), {31'd0, wr_en}, 32'd1);
            chk($sformatf("clr_addr%0d", i), {22'd0, wr_addr}, i);
            chk($sformatf("clr_data%0d", i), {31'd0, wr_data}, 32'd0);
            chk($sformatf("clr_done%0d", i), {31'd0, clear_done}, (i == 783) ? 32'd1 : 32'd0);
            if (i == 100) clear_btn = 1'b0;
            if (i == 101) clear_btn = 1'b1;
            if (i == 102) clear_btn = 1'b0;
            step();
        end
        chk("clr_end_busy", {31'd0, busy}, 32'd0);
        chk("clr_end_en", {31'd0, wr_en}, 32'd0);
        chk("clr_end_done", {31'd0, clear_done}, 32'd0);

        // Stamp at (283,160): row 5, col 10 -> 150, 122, 178, 149, 151.
        X_pos = 10'd283;
        Y_pos = 10'd160;
        draw_btn = 1'b1;
        step();
        chk_stamp("mid", 5'b11111, 10'd150, 10'd122, 10'd178, 10'd149, 10'd151);
        // Holding on the same cell must not restamp.
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("hold_busy%0d", i), {31'd0, busy}, 32'd0);
            chk($sformatf("hold_en%0d", i), {31'd0, wr_en}, 32'd0);
            chk($sformatf("hold_infer%0d", i), {31'd0, infer_req}, 32'd0);
            step();
        end
        draw_btn = 1'b0;
        step();
        chk("rel1_infer", {31'd0, infer_req}, 32'd1);
        step();
        chk("rel1_infer_off", {31'd0, infer_req}, 32'd0);

        // Top-left cell 0: up and left neighbours fall off the canvas.
        X_pos = 10'd200;
        Y_pos = 10'd120;
        draw_btn = 1'b1;
        step();
        chk_stamp("tl", 5'b10101, 10'd0, 10'd0, 10'd28, 10'd0, 10'd1);
        chk("tl_idle_busy", {31'd0, busy}, 32'd0);
        draw_btn = 1'b0;
        step();
        chk("rel2_infer", {31'd0, infer_req}, 32'd1);
        step();
        chk("rel2_infer_off", {31'd0, infer_req}, 32'd0);

        // Just outside the canvas on the right and left: no stamp.
        X_pos = 10'd424;
        Y_pos = 10'd160;
        draw_btn = 1'b1;
        step();
        chk("out_r_busy", {31'd0, busy}, 32'd0);
        chk("out_r_en", {31'd0, wr_en}, 32'd0);
        X_pos = 10'd199;
        step();
        chk("out_l_busy", {31'd0, busy}, 32'd0);
        step();
        chk("out_l_busy2", {31'd0, busy}, 32'd0);

        // Bottom-right cell 783: down and right neighbours fall off.
        X_pos = 10'd416;
        Y_pos = 10'd336;
        step();
        chk_stamp("br", 5'b01011, 10'd783, 10'd755, 10'd0, 10'd782, 10'd0);
        draw_btn = 1'b0;
        step();
        chk("rel3_infer", {31'd0, infer_req}, 32'd1);
        step();

        // Clear edge in the 3rd stamp cycle aborts the stamp.
        X_pos = 10'd283;
        Y_pos = 10'd160;
        draw_btn = 1'b1;
        step();
        chk("ab_addr0", {22'd0, wr_addr}, 32'd150);
        step();
        chk("ab_addr1", {22'd0, wr_addr}, 32'd122);
        step();
        chk("ab_addr2", {22'd0, wr_addr}, 32'd178);
        chk("ab_en2", {31'd0, wr_en}, 32'd1);
        clear_btn = 1'b1;
        step();
        chk("ab_clr_addr", {22'd0, wr_addr}, 32'd0);
        chk("ab_clr_data", {31'd0, wr_data}, 32'd0);
        chk("ab_clr_busy", {31'd0, busy}, 32'd1);
        draw_btn = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            saw = saw | infer_req;
        end
        chk("ab_no_infer", {31'd0, saw}, 32'd0);
        chk("clr400_addr", {22'd0, wr_addr}, 32'd400);
        chk("clr400_en", {31'd0, wr_en}, 32'd1);

        // Reset in the middle of the sweep abandons it.
        Reset = 1'b1;
        clear_btn = 1'b0;
        step();
        chk_idle_outputs("mid_reset");
        Reset = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            saw = saw | wr_en | busy;
        end
        chk("after_reset_quiet", {31'd0, saw}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/canvas_painter.md
CANVAS_PAINTER -- requirements
Module: canvas_painter

Interface
REQ-001 Parameter CANVAS_X0, default 200, meaning screen X of canvas left edge in pixels.
REQ-002 Parameter CANVAS_Y0, default 120, meaning screen Y of canvas top edge in pixels.
REQ-003 Parameter CELL_SHIFT, default 3, meaning log2 of the cell size in pixels (8 px cells, 224x224 px canvas).
REQ-004 frame_clk  in  1  clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 X_pos, Y_pos  in  10 each  pointer screen position, sampled every cycle.
REQ-007 draw_btn  in  1  draw button level, already synchronous to frame_clk.
REQ-008 clear_btn  in  1  clear button level, already synchronous to frame_clk.
REQ-009 wr_en  out  1  canvas RAM write strobe.
REQ-010 wr_addr  out  10  canvas cell address, row*28+col, range 0..783.
REQ-011 wr_data  out  1  pixel value to write.
REQ-012 busy  out  1  high while in CLEAR or STAMP.
REQ-013 infer_req  out  1  one-cycle pulse requesting classification.
REQ-014 clear_done  out  1  one-cycle pulse when a clear sweep completes.

Function
REQ-015 The FSM SHALL have three states: IDLE, CLEAR and STAMP.
REQ-016 Mapping SHALL give col=(X_pos-CANVAS_X0)>>CELL_SHIFT and row=(Y_pos-CANVAS_Y0)>>CELL_SHIFT, valid only when CANVAS_X0<=X_pos<CANVAS_X0+224 and CANVAS_Y0<=Y_pos<CANVAS_Y0+224.
REQ-017 Address SHALL be row*28+col, computed as (row<<5)-(row<<2)+col without a multiplier.
REQ-018 A clear_btn rising edge (0 to 1 between consecutive cycles) SHALL set a pending-clear flag; this flag has priority over all other transitions.
REQ-019 In IDLE with pending clear: go to CLEAR next cycle, index=0.
REQ-020 CLEAR SHALL write wr_data=0 to addresses 0..783, one per cycle, in ascending order (784 cycles); after address 783 it returns to IDLE and pulses clear_done in the same cycle as the last write.
REQ-021 In IDLE with draw_btn=1, mapping valid, and (first stamp of stroke or cell != last stamped cell): latch the cell and enter STAMP.
REQ-022 STAMP SHALL take exactly 5 cycles: center, up (row-1), down (row+1), left (col-1), right (col+1), all with wr_data=1.
REQ-023 A neighbour outside the 0..27 range SHALL consume its cycle with wr_en=0; there is no wrap-around to the opposite edge.
REQ-024 A pending clear arriving during STAMP SHALL abort STAMP after the current cycle and enter CLEAR.
REQ-025 A new clear_btn edge during CLEAR SHALL be ignored; the sweep continues without restarting.
REQ-026 stroke_active SHALL set on the first stamp and clear on a draw_btn falling edge; that falling edge SHALL pulse infer_req for one cycle, even when it occurs during STAMP.
REQ-027 A clear SHALL reset stroke_active without pulsing infer_req.
REQ-028 Pointer motion while in STAMP SHALL be ignored; the next cell is evaluated on return to IDLE.
REQ-029 When wr_en=0, wr_addr and wr_data SHALL be don't-care.

Reset
REQ-030 On Reset the block SHALL enter IDLE.
REQ-031 Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, infer_req=0, clear_done=0; pending-clear, stroke_active, last-cell valid and button-history registers all 0.
REQ-032 Reset mid-CLEAR or mid-STAMP SHALL abandon the operation immediately with no further writes.

Structure
REQ-033 A shared package canvas_pkg SHALL hold GRID=28, CANVAS_CELLS=784, the state enum, and the canvas address type (10-bit).
REQ-034 One sub-module, canvas_mapper, SHALL be combinational: position to {valid, row, col, addr}.

Verification
REQ-035 Reset, then clear_btn 0->1 -> busy high 784 cycles, addresses 0..783 with wr_data=0, clear_done pulses with addr 783.
REQ-036 draw_btn=1 at (283,160) -> writes 150, 122, 178, 149, 151 on consecutive cycles, busy for 5 cycles.
REQ-037 draw_btn=1 at (200,120), cell 0 -> writes 0, then skip, then 28, then skip, then 1; wr_en=0 on both skip cycles.
REQ-038 Hold draw_btn at same cell 20 cycles -> exactly one stamp; release -> one infer_req pulse.
REQ-039 clear_btn edge during the 3rd STAMP cycle -> no 4th write, CLEAR starts next cycle, no infer_req on later release.
REQ-040 Reset asserted at CLEAR index 400 -> wr_en=0 from next cycle, IDLE, all outputs at reset values.
